// File: rtl/gpio_comm_pkg.sv
// Shared constants and types for the Pulpino-side GPIO byte-handshake agent.
package gpio_comm_pkg;

    localparam int unsigned TURN_TOGGLE = 0;
    localparam int unsigned TURN_LAST   = 1;
    localparam int unsigned TURN_ROOM   = 1;

    localparam int unsigned FIFO_W = 9;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSetup   = 2'd1,
        StWaitAck = 2'd2
    } tx_state_e;

endpackage

// File: rtl/gpio_comm_byte_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head entry is read straight from the storage flops.
module gpio_comm_byte_fifo #(
    parameter int unsigned pDEPTH = 16,
    parameter int unsigned pWIDTH = 9
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_wr,
    input  logic [pWIDTH-1:0] i_wdata,
    input  logic              i_rd,
    output logic              o_full,
    output logic              o_full_nxt,
    output logic              o_empty,
    output logic [pWIDTH-1:0] o_rdata
);

    localparam int unsigned AW = $clog2(pDEPTH);

    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       w_wr_ptr_nxt;
    logic [AW:0]       w_rd_ptr_nxt;
    logic [pWIDTH-1:0] r_mem [pDEPTH];

    assign w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, i_wr};
    assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, i_rd};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(pDEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            if (i_wr) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
            end
        end
    end

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_full_nxt = (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                        (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
    assign o_rdata    = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/gpio_comm_pulpino_agent.sv
// Pulpino-side agent for the GPIO byte-handshake link: RX capture into a FIFO plus a TX FSM.
// Define GPIO_COMM_SYNC_EN to add a 2-flop synchroniser on the IO-side turn inputs.
module gpio_comm_pulpino_agent
    import gpio_comm_pkg::*;
#(
    parameter int unsigned pRX_DEPTH    = 16,
    parameter int unsigned pACK_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] gpio_data_in,
    input  logic [1:0] data_in_io_turn,
    output logic [1:0] data_in_pulpino_turn,
    output logic [7:0] gpio_data_out,
    output logic [1:0] data_out_pulpino_turn,
    input  logic       data_out_io_turn,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_overflow,
    output logic       tx_timeout
);

    localparam int unsigned CW = (pACK_TIMEOUT > 0) ? $clog2(pACK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(pACK_TIMEOUT);
    localparam bit TO_EN = (pACK_TIMEOUT != 0);

    // {in_last, in_toggle, out_ack} as seen by the input register
    logic [2:0] w_tog_src;
    logic       w_data_ld;

    logic [7:0] r_data_in;
    logic [1:0] r_in_turn;
    logic       r_out_ack;

`ifdef GPIO_COMM_SYNC_EN
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {data_in_io_turn, data_out_io_turn};
            r_sync2 <= r_sync1;
        end
    end

    assign w_tog_src = r_sync2;
    assign w_data_ld = (w_tog_src[1] != r_in_turn[TURN_TOGGLE]);
`else
    assign w_tog_src = {data_in_io_turn, data_out_io_turn};
    assign w_data_ld = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data_in <= '0;
            r_in_turn <= '0;
            r_out_ack <= 1'b0;
        end else begin
            r_in_turn <= w_tog_src[2:1];
            r_out_ack <= w_tog_src[0];
            if (w_data_ld) begin
                r_data_in <= gpio_data_in;
            end
        end
    end

    // RX capture
    logic              r_ack;
    logic              r_room;
    logic              r_overflow;
    logic              w_pending;
    logic              w_tog_change;
    logic              w_wr;
    logic              w_rd;
    logic              w_full;
    logic              w_full_nxt;
    logic              w_empty;
    logic [FIFO_W-1:0] w_head;

    assign w_pending    = (r_in_turn[TURN_TOGGLE] != r_ack);
    assign w_tog_change = (w_tog_src[1] != r_in_turn[TURN_TOGGLE]);
    assign w_rd         = rx_ready && !w_empty;
    // A read in the same cycle frees the slot, so a full FIFO can still accept
    assign w_wr         = w_pending && (!w_full || w_rd);

    gpio_comm_byte_fifo #(
        .pDEPTH (pRX_DEPTH),
        .pWIDTH (FIFO_W)
    ) u_rx_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .i_wr       (w_wr),
        .i_wdata    ({r_in_turn[TURN_LAST], r_data_in}),
        .i_rd       (w_rd),
        .o_full     (w_full),
        .o_full_nxt (w_full_nxt),
        .o_empty    (w_empty),
        .o_rdata    (w_head)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ack      <= 1'b0;
            r_room     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_room <= !w_full_nxt;
            if (w_wr) begin
                r_ack <= ~r_ack;
            end
            if (w_tog_change && w_pending) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign data_in_pulpino_turn[TURN_TOGGLE] = r_ack;
    assign data_in_pulpino_turn[TURN_ROOM]   = r_room;
    assign rx_valid    = !w_empty;
    assign rx_data     = w_head[7:0];
    assign rx_last     = w_head[8];
    assign rx_overflow = r_overflow;

    // TX FSM
    tx_state_e     r_state;
    tx_state_e     w_state_nxt;
    logic          w_load;
    logic          w_flip;
    logic          r_alive;
    logic [7:0]    r_tx_byte;
    logic          r_tx_last;
    logic          r_tog;
    logic          r_turn_last;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic          r_timeout;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_flip      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (tx_valid && r_alive) begin
                    w_load      = 1'b1;
                    w_state_nxt = StSetup;
                end
            end
            StSetup: begin
                w_flip      = 1'b1;
                w_state_nxt = StWaitAck;
            end
            StWaitAck: begin
                if (r_out_ack == r_tog) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign w_cnt_inc = r_cnt + CW'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= StIdle;
            r_alive     <= 1'b0;
            r_tx_byte   <= '0;
            r_tx_last   <= 1'b0;
            r_tog       <= 1'b0;
            r_turn_last <= 1'b0;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
            if (w_load) begin
                r_tx_byte <= tx_data;
                r_tx_last <= tx_last;
            end
            if (w_flip) begin
                r_tog       <= ~r_tog;
                r_turn_last <= r_tx_last;
                r_cnt       <= '0;
            end else if (TO_EN && (r_state == StWaitAck) && (w_state_nxt == StWaitAck) &&
                         (r_cnt != TMAX)) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == TMAX) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign tx_ready      = r_alive && (r_state == StIdle);
    assign gpio_data_out = r_tx_byte;
    assign data_out_pulpino_turn[TURN_TOGGLE] = r_tog;
    assign data_out_pulpino_turn[TURN_LAST]   = r_turn_last;
    assign tx_timeout    = r_timeout;

endmodule

// File: tb/tb_gpio_comm_pulpino_agent.sv
// Directed, table-driven bench for gpio_comm_pulpino_agent (timeout shortened to 8 cycles).
module tb_gpio_comm_pulpino_agent;

`ifdef GPIO_COMM_SYNC_EN
    localparam int RX_LAT = 4;
    localparam int TX_LAT = 4;
`else
    localparam int RX_LAT = 2;
    localparam int TX_LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] gpio_data_in;
    logic [1:0] data_in_io_turn;
    logic [1:0] data_in_pulpino_turn;
    logic [7:0] gpio_data_out;
    logic [1:0] data_out_pulpino_turn;
    logic       data_out_io_turn;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       rx_overflow;
    logic       tx_timeout;

    int total = 0;
    int bad   = 0;
    logic io_tog = 1'b0;
    logic out_tog = 1'b0;

    always #5 clk = ~clk;

    gpio_comm_pulpino_agent #(
        .pRX_DEPTH    (16),
        .pACK_TIMEOUT (8)
    ) dut (
        .clk                   (clk),
        .resetn                (resetn),
        .gpio_data_in          (gpio_data_in),
        .data_in_io_turn       (data_in_io_turn),
        .data_in_pulpino_turn  (data_in_pulpino_turn),
        .gpio_data_out         (gpio_data_out),
        .data_out_pulpino_turn (data_out_pulpino_turn),
        .data_out_io_turn      (data_out_io_turn),
        .rx_valid              (rx_valid),
        .rx_ready              (rx_ready),
        .rx_data               (rx_data),
        .rx_last               (rx_last),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready),
        .tx_data               (tx_data),
        .tx_last               (tx_last),
        .rx_overflow           (rx_overflow),
        .tx_timeout            (tx_timeout)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] exp_data;
        logic       exp_last;
    } rx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] exp_out;
        logic [1:0] exp_turn_hi;
    } tx_vec_t;

    rx_vec_t rx_tab[4];
    tx_vec_t tx_tab[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_rx_ack();
        for (int i = 0; i < 30; i++) begin
            if (data_in_pulpino_turn[0] == io_tog) break;
            tick();
        end
        check("rx_ack_wait", {31'd0, data_in_pulpino_turn[0]}, {31'd0, io_tog});
    endtask

    task automatic io_send(input logic [7:0] d, input logic last, input bit wait_ack);
        gpio_data_in = d;
        tick();
        io_tog = ~io_tog;
        data_in_io_turn = {last, io_tog};
        if (wait_ack) wait_rx_ack();
    endtask

    task automatic pop();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_tx_ready();
        for (int i = 0; i < 30; i++) begin
            if (tx_ready) break;
            tick();
        end
        check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        gpio_data_in = '0;
        data_in_io_turn = '0;
        data_out_io_turn = 1'b0;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data = '0;
        tx_last = 1'b0;
        io_tog = 1'b0;
        out_tog = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rx_tab[0] = '{8'h11, 1'b0, 8'h11, 1'b0};
        rx_tab[1] = '{8'h22, 1'b0, 8'h22, 1'b0};
        rx_tab[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
        rx_tab[3] = '{8'h00, 1'b1, 8'h00, 1'b1};
        tx_tab[0] = '{8'h3C, 1'b1, 8'h3C, 2'b11};
        tx_tab[1] = '{8'hA5, 1'b0, 8'hA5, 2'b00};
        tx_tab[2] = '{8'h00, 1'b1, 8'h00, 2'b11};
        tx_tab[3] = '{8'hFF, 1'b0, 8'hFF, 2'b00};

        // Reset with toggling inputs: every output must stay 0
        resetn = 1'b0;
        rx_ready = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'h5A;
        tx_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            gpio_data_in = 8'(i * 37);
            data_in_io_turn = 2'(i);
            data_out_io_turn = i[0];
            tick();
            check("reset_outputs",
                  {data_in_pulpino_turn, gpio_data_out, data_out_pulpino_turn, rx_valid, rx_data,
                   rx_last, tx_ready, rx_overflow, tx_timeout}, 32'd0);
        end
        gpio_data_in = '0;
        data_in_io_turn = '0;
        data_out_io_turn = 1'b0;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        resetn = 1'b1;
        tick();
        check("room_after_reset", {30'd0, data_in_pulpino_turn}, 32'h2);
        check("tx_ready_after_reset", {31'd0, tx_ready}, 32'd1);

        // RX single byte with exact ack latency
        gpio_data_in = 8'hA5;
        tick();
        io_tog = 1'b1;
        data_in_io_turn = 2'b01;
        for (int i = 0; i < RX_LAT - 1; i++) begin
            tick();
            check("rx_ack_early", {31'd0, data_in_pulpino_turn[0]}, 32'd0);
        end
        tick();
        check("rx_ack_latency", {31'd0, data_in_pulpino_turn[0]}, 32'd1);
        check("rx_single_valid", {31'd0, rx_valid}, 32'd1);
        check("rx_single_data", {24'd0, rx_data}, 32'hA5);
        check("rx_single_last", {31'd0, rx_last}, 32'd0);
        pop();
        check("rx_single_drained", {31'd0, rx_valid}, 32'd0);

        // RX stream table
        for (int i = 0; i < 4; i++) io_send(rx_tab[i].data, rx_tab[i].last, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("rx_tab_valid", {31'd0, rx_valid}, 32'd1);
            check("rx_tab_data", {24'd0, rx_data}, {24'd0, rx_tab[i].exp_data});
            check("rx_tab_last", {31'd0, rx_last}, {31'd0, rx_tab[i].exp_last});
            pop();
        end
        check("rx_tab_empty", {31'd0, rx_valid}, 32'd0);

        // RX full: 16 fit, 17th held without loss
        for (int i = 0; i < 16; i++) io_send(8'(i), 1'b0, 1'b1);
        tick();
        check("rx_full_room", {31'd0, data_in_pulpino_turn[1]}, 32'd0);
        io_send(8'h10, 1'b0, 1'b0);
        repeat (10) tick();
        check("rx_17th_unacked", {31'd0, data_in_pulpino_turn[0]}, {31'd0, ~io_tog});
        check("rx_17th_room", {31'd0, data_in_pulpino_turn[1]}, 32'd0);
        check("rx_full_head", {24'd0, rx_data}, 32'h00);
        pop();
        check("rx_17th_acked", {31'd0, data_in_pulpino_turn[0]}, {31'd0, io_tog});
        check("rx_rdwr_full_room", {31'd0, data_in_pulpino_turn[1]}, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            check("rx_drain_valid", {31'd0, rx_valid}, 32'd1);
            check("rx_drain_data", {24'd0, rx_data}, i);
            pop();
        end
        check("rx_drain_empty", {31'd0, rx_valid}, 32'd0);
        check("rx_no_overflow", {31'd0, rx_overflow}, 32'd0);
        check("rx_room_back", {31'd0, data_in_pulpino_turn[1]}, 32'd1);

        // TX table
        for (int i = 0; i < 4; i++) begin
            wait_tx_ready();
            tx_valid = 1'b1;
            tx_data = tx_tab[i].data;
            tx_last = tx_tab[i].last;
            tick();
            tx_valid = 1'b0;
            check("tx_data_out", {24'd0, gpio_data_out}, {24'd0, tx_tab[i].exp_out});
            check("tx_busy", {31'd0, tx_ready}, 32'd0);
            check("tx_setup_turn", {31'd0, data_out_pulpino_turn[0]}, {31'd0, out_tog});
            tick();
            out_tog = ~out_tog;
            check("tx_turn", {30'd0, data_out_pulpino_turn},
                  {30'd0, tx_tab[i].exp_turn_hi[1], out_tog});
            data_out_io_turn = out_tog;
            for (int k = 0; k < TX_LAT - 1; k++) begin
                tick();
                check("tx_ack_early", {31'd0, tx_ready}, 32'd0);
            end
            tick();
            check("tx_ack_idle", {31'd0, tx_ready}, 32'd1);
            check("tx_hold_out", {24'd0, gpio_data_out}, {24'd0, tx_tab[i].exp_out});
        end
        check("tx_no_timeout", {31'd0, tx_timeout}, 32'd0);

        // TX ack timeout, then a late ack
        tx_valid = 1'b1;
        tx_data = 8'h77;
        tx_last = 1'b0;
        tick();
        tx_valid = 1'b0;
        tick();
        out_tog = ~out_tog;
        repeat (7) tick();
        check("tx_timeout_early", {31'd0, tx_timeout}, 32'd0);
        tick();
        check("tx_timeout_set", {31'd0, tx_timeout}, 32'd1);
        repeat (5) tick();
        check("tx_still_waiting", {31'd0, tx_ready}, 32'd0);
        data_out_io_turn = out_tog;
        wait_tx_ready();
        check("tx_timeout_sticky", {31'd0, tx_timeout}, 32'd1);

        // Double toggle without ack
        gpio_data_in = 8'h99;
        tick();
        io_tog = ~io_tog;
        data_in_io_turn = {1'b0, io_tog};
        tick();
        io_tog = ~io_tog;
        data_in_io_turn = {1'b0, io_tog};
        repeat (6) tick();
        check("rx_overflow_set", {31'd0, rx_overflow}, 32'd1);

        do_reset();
        check("overflow_cleared", {31'd0, rx_overflow}, 32'd0);
        check("timeout_cleared", {31'd0, tx_timeout}, 32'd0);
        check("reset_rx_empty", {31'd0, rx_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
